// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one synchronous data-RAM port between
//   NUM_REQ cores. One transaction in flight at a time; reads wait MEM_LAT
//   cycles and return data with a one-cycle rvalid pulse to the winner.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   req/req_we               per-core request and write flag
//   req_addr/req_wdata       per-core address/data, slice i = [i*W +: W]
//   gnt                      one-hot grant pulse (cycle the RAM strobe is high)
//   rvalid/rdata             one-hot read-valid pulse, broadcast read data
//   busy                     high whenever the FSM is not idle
//   mem_addr/mem_wdata       RAM address and write data
//   mem_we/mem_re            RAM write/read strobes
//   mem_rdata                RAM read data (valid MEM_LAT cycles after mem_re)
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int          IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [NUM_REQ-1:0] BIT0     = NUM_REQ'(1);
  localparam idx_t               LAST_IDX = idx_t'(NUM_REQ - 1);

  state_t state;
  idx_t   rr_ptr;
  idx_t   win_q;
  logic   we_q;
  cnt_t   cnt;

  idx_t   win_idx;
  logic   any_req;

  function automatic idx_t wrap_idx(input idx_t base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ_U) s = s - NREQ_U;
    return idx_t'(s);
  endfunction

  // Scan offsets from the far end down to 0 so the nearest set bit at or
  // above rr_ptr overwrites any farther candidate.
  always_comb begin
    any_req = |req;
    win_idx = '0;
    for (int unsigned k = NREQ_U; k > 0; k--) begin
      if (req[wrap_idx(rr_ptr, k - 1)]) win_idx = wrap_idx(rr_ptr, k - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_q     <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      case (state)
        // Strobes and gnt are registered here so they are visible during ISSUE.
        IDLE: begin
          if (any_req) begin
            win_q     <= win_idx;
            we_q      <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            gnt       <= BIT0 << win_idx;
            mem_we    <= req_we[win_idx];
            mem_re    <= ~req_we[win_idx];
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          gnt    <= '0;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          rr_ptr <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
          if (we_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= cnt_t'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata  <= mem_rdata;
            rvalid <= BIT0 << win_q;
            state  <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rvalid <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt    <= '0;
          rvalid <= '0;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WAIT_LIMIT = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: MEM_LAT = 1
  logic [NR-1:0]    req, req_we, gnt, rvalid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;
  logic             busy, mem_we, mem_re;

  // Instance B: MEM_LAT = 3
  logic [NR-1:0]    req_b, req_we_b, gnt_b, rvalid_b;
  logic [NR*AW-1:0] req_addr_b;
  logic [NR*DW-1:0] req_wdata_b;
  logic [DW-1:0]    rdata_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0]    mem_addr_b;
  logic             busy_b, mem_we_b, mem_re_b;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_we(req_we_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_re(mem_re_b),
    .mem_rdata(mem_rdata_b)
  );

  // RAM models with a backdoor poke port
  logic [DW-1:0] ram   [256];
  logic [DW-1:0] ram_b [256];
  logic          poke_en = 1'b0, poke_b_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  logic [DW-1:0] pipe0_b, pipe1_b;

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (poke_b_en) ram_b[poke_addr] <= poke_data;
    else if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
    if (mem_re_b) pipe0_b <= ram_b[mem_addr_b];
    pipe1_b     <= pipe0_b;
    mem_rdata_b <= pipe1_b;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_b = '0; req_we_b = '0; req_addr_b = '0; req_wdata_b = '0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic poke(input bit to_b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_addr = a;
    poke_data = d;
    if (to_b) poke_b_en = 1'b1; else poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
    poke_b_en = 1'b0;
  endtask

  task automatic set_core(input int i, input bit r, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h busy=%b addr=%h wdata=%h we=%b re=%b, required all 0",
               gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re);
    end
    checks++;
    if ({gnt_b, rvalid_b, busy_b, mem_we_b, mem_re_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_lat3: gnt=%b rvalid=%b busy=%b, required 0", gnt_b, rvalid_b, busy_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    poke(1'b0, 8'h10, 8'h5A);
    set_core(2, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    checks++;
    if (gnt !== 4'b0100 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_issue: gnt=%b re=%b we=%b addr=%h busy=%b, required 0100 1 0 10 1",
               gnt, mem_re, mem_we, mem_addr, busy);
    end
    req = '0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || mem_re !== 1'b0 || rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL read_wait: gnt=%b re=%b rvalid=%b, required 0000 0 0000", gnt, mem_re, rvalid);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0100 || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_resp: rvalid=%b rdata=%h, required 0100 5a", rvalid, rdata);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_end: rvalid=%b busy=%b, required 0000 0", rvalid, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [NR-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < NR; i++) set_core(i, 1'b1, 1'b1, AW'(8'h80 + i), DW'(i));
    for (int n = 0; n < 6; n++) begin
      exp_g = 4'b0001 << (n % NR);
      tick();
      checks++;
      if (gnt !== exp_g || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b we=%b, required %b 1", n, gnt, mem_we, exp_g);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_pulse%0d: gnt=%b, required 0000", n, gnt);
      end
    end
    req = '0;
    req_we = '0;
    tick();
  endtask

  task automatic test_write_readback;
    set_core(1, 1'b1, 1'b1, 8'h22, 8'hC3);
    tick();
    checks++;
    if (gnt !== 4'b0010 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h22 || mem_wdata !== 8'hC3) begin
      errors++;
      $display("FAIL write_issue: gnt=%b we=%b re=%b addr=%h wdata=%h, required 0010 1 0 22 c3",
               gnt, mem_we, mem_re, mem_addr, mem_wdata);
    end
    set_core(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL write_done: busy=%b we=%b, required 0 0", busy, mem_we);
    end
    set_core(3, 1'b1, 1'b0, 8'h22, 8'h00);
    tick();
    checks++;
    if (gnt !== 4'b1000 || mem_re !== 1'b1) begin
      errors++;
      $display("FAIL readback_issue: gnt=%b re=%b, required 1000 1", gnt, mem_re);
    end
    req = '0;
    tick();
    tick();
    checks++;
    if (rvalid !== 4'b1000 || rdata !== 8'hC3) begin
      errors++;
      $display("FAIL readback_resp: rvalid=%b rdata=%h, required 1000 c3", rvalid, rdata);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0000 || rdata !== 8'hC3) begin
      errors++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h, required 0000 c3", rvalid, rdata);
    end
  endtask

  task automatic test_latency;
    int n, re_cnt;
    bit got;
    poke(1'b1, 8'h40, 8'h77);
    req_b[0] = 1'b1;
    req_we_b[0] = 1'b0;
    req_addr_b[0 +: AW] = 8'h40;
    n = 0; re_cnt = 0; got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      n++;
      if (mem_re_b) re_cnt++;
      if (n == 1) begin
        checks++;
        if (gnt_b !== 4'b0001) begin
          errors++;
          $display("FAIL lat3_grant: gnt=%b, required 0001", gnt_b);
        end
        req_b = '0;
      end
      if (rvalid_b !== 4'b0000) got = 1'b1;
    end
    checks++;
    if (!got || n != 5) begin
      errors++;
      $display("FAIL lat3_req_to_rvalid: cycles=%0d seen=%0d, required 5 1", n, got);
    end
    checks++;
    if (rvalid_b !== 4'b0001 || rdata_b !== 8'h77) begin
      errors++;
      $display("FAIL lat3_resp: rvalid=%b rdata=%h, required 0001 77", rvalid_b, rdata_b);
    end
    checks++;
    if (re_cnt != 1) begin
      errors++;
      $display("FAIL lat3_re_pulse: mem_re cycles=%0d, required 1", re_cnt);
    end
    tick();
    checks++;
    if (rvalid_b !== 4'b0000 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL lat3_end: rvalid=%b busy=%b, required 0000 0", rvalid_b, busy_b);
    end
  endtask

  task automatic test_reset_mid_read;
    int rv_seen;
    apply_reset();
    set_core(0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    req = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL midread_in_wait: busy=%b gnt=%b, required 1 0000", busy, gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re} !== '0) begin
      errors++;
      $display("FAIL midread_async_clear: gnt=%b rvalid=%b rdata=%h busy=%b addr=%h we=%b re=%b, required all 0",
               gnt, rvalid, rdata, busy, mem_addr, mem_we, mem_re);
    end
    tick();
    rst_n = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rvalid !== 4'b0000) rv_seen++;
    end
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL midread_no_rvalid: rvalid cycles=%0d, required 0", rv_seen);
    end
    for (int i = 0; i < NR; i++) set_core(i, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midread_first_grant: gnt=%b, required 0001", gnt);
    end
    req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_random;
    bit            pend [NR];
    int            wcnt [NR];
    logic [NR-1:0] pend_vec;
    int            exp_t, exp_core;
    logic [DW-1:0] exp_d;
    int            leftover;
    clear_inputs();
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; wcnt[i] = 0; end
    exp_t = -1; exp_core = 0; exp_d = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      for (int i = 0; i < NR; i++) pend_vec[i] = pend[i];
      checks++;
      if (mem_we && mem_re) begin
        errors++;
        $display("FAIL rnd_we_re_excl@%0d: we=%b re=%b, required not both", cyc, mem_we, mem_re);
      end
      checks++;
      if (!$onehot0(gnt) || !$onehot0(rvalid)) begin
        errors++;
        $display("FAIL rnd_onehot@%0d: gnt=%b rvalid=%b, required onehot0", cyc, gnt, rvalid);
      end
      checks++;
      if ((gnt & ~pend_vec) !== 4'b0000) begin
        errors++;
        $display("FAIL rnd_spurious_gnt@%0d: gnt=%b pending=%b", cyc, gnt, pend_vec);
      end
      checks++;
      if (cyc == exp_t) begin
        if (rvalid !== (4'b0001 << exp_core) || rdata !== exp_d) begin
          errors++;
          $display("FAIL rnd_rvalid@%0d: rvalid=%b rdata=%h, required %b %h",
                   cyc, rvalid, rdata, 4'b0001 << exp_core, exp_d);
        end
      end else if (rvalid !== 4'b0000) begin
        errors++;
        $display("FAIL rnd_rvalid_idle@%0d: rvalid=%b, required 0000", cyc, rvalid);
      end
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && gnt[i]) begin
          if (!req_we[i]) begin
            exp_t = cyc + 2;
            exp_core = i;
            exp_d = ram[req_addr[i*AW +: AW]];
          end
          pend[i] = 1'b0;
          wcnt[i] = 0;
          set_core(i, 1'b0, 1'b0, 8'h00, 8'h00);
        end else if (pend[i]) begin
          wcnt[i]++;
          if (wcnt[i] == WAIT_LIMIT) begin
            checks++;
            errors++;
            $display("FAIL rnd_starve core%0d: waited %0d cycles, required < %0d", i, wcnt[i], WAIT_LIMIT);
          end
        end else if (cyc < 1950 && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          set_core(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(255)), DW'($urandom_range(255)));
        end
      end
    end
    leftover = 0;
    for (int i = 0; i < NR; i++) if (pend[i]) leftover++;
    checks++;
    if (leftover != 0) begin
      errors++;
      $display("FAIL rnd_all_granted: pending=%0d, required 0", leftover);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_readback();
    test_latency();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
